// File: rtl/adc_spi_dual.sv
`default_nettype none
// ============================================================================
//  Module   : adc_spi_dual
//  Purpose  : SPI master sweeping NUM_CH channels on two ADCs sharing CSn/SCLK/
//             MOSI, capturing both MISO words per frame for a fs/fd handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_spi_dual #(
   parameter int NUM_CH   = 32,
   parameter int SCLK_DIV = 4,
   parameter int CS_GAP   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [5:0]  ch_idx,
   output logic        spi_csn,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_misoa,
   input  logic        spi_misob,
   output logic        fs,
   input  logic        fd,
   output logic [15:0] chip_rxda,
   output logic [15:0] chip_rxdb
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_HAND  = 3'd4;
   localparam logic [2:0] S_RELS  = 3'd5;
   localparam logic [2:0] S_NEXT  = 3'd6;

   localparam int c_CNT_MAX = (SCLK_DIV > CS_GAP) ? SCLK_DIV : CS_GAP;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(SCLK_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(CS_GAP - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [5:0]         c_LAST_CH  = 6'(NUM_CH - 1);

   logic [2:0]         state_q, state_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]         bit_q, bit_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic [15:0]        sh_a_q, sh_a_d, sh_b_q, sh_b_d;
   logic [15:0]        rxa_q, rxa_d, rxb_q, rxb_d;
   logic [5:0]         ch_q, ch_d;

   logic        w_div_end;
   logic        w_gap_end;
   logic        w_last_ch;
   logic [15:0] w_cmd;

   assign w_div_end = (cnt_q == c_DIV_LAST);
   assign w_gap_end = (cnt_q == c_GAP_LAST);
   assign w_last_ch = (ch_q == c_LAST_CH);
   assign w_cmd     = {2'b00, ch_q, 8'h00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: if (w_div_end) state_d = S_SHIFT;
         S_SHIFT: if (w_div_end && sclk_q && (bit_q == 4'd15)) state_d = S_GAP;
         // fd still high from a previous handoff holds us here with csn high
         S_GAP:   if (w_gap_end && !fd) state_d = S_HAND;
         S_HAND:  if (fd) state_d = S_RELS;
         S_RELS:  if (!fd) state_d = S_NEXT;
         S_NEXT:  state_d = w_last_ch ? S_IDLE : S_SETUP;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      spi_csn = !((state_q == S_SETUP) || (state_q == S_SHIFT));
      fs      = (state_q == S_HAND);
      done    = (state_q == S_NEXT) && w_last_ch;
      busy    = (state_q != S_IDLE) && !done;
   end

   always_comb begin
      cnt_d  = cnt_q;
      bit_d  = bit_q;
      sclk_d = sclk_q;
      mosi_d = 1'b0;
      sh_a_d = sh_a_q;
      sh_b_d = sh_b_q;
      rxa_d  = rxa_q;
      rxb_d  = rxb_q;
      ch_d   = ch_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) ch_d = 6'd0;
         end
         S_SETUP: begin
            mosi_d = w_cmd[15];
            bit_d  = 4'd0;
            sclk_d = 1'b0;
            cnt_d  = w_div_end ? '0 : cnt_q + c_CNT_ONE;
         end
         S_SHIFT: begin
            mosi_d = mosi_q;
            if (w_div_end) begin
               cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  sh_a_d = {sh_a_q[14:0], spi_misoa};
                  sh_b_d = {sh_b_q[14:0], spi_misob};
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q != 4'd15) begin
                     bit_d  = bit_q + 4'd1;
                     mosi_d = w_cmd[4'd14 - bit_q];
                  end else begin
                     mosi_d = 1'b0;
                  end
               end
            end else begin
               cnt_d = cnt_q + c_CNT_ONE;
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               rxa_d = sh_a_q;
               rxb_d = sh_b_q;
            end
            if (!w_gap_end) cnt_d = cnt_q + c_CNT_ONE;
         end
         S_NEXT: begin
            cnt_d = '0;
            ch_d  = w_last_ch ? 6'd0 : ch_q + 6'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         bit_q  <= 4'd0;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
         sh_a_q <= 16'h0000;
         sh_b_q <= 16'h0000;
         rxa_q  <= 16'h0000;
         rxb_q  <= 16'h0000;
         ch_q   <= 6'd0;
      end else begin
         cnt_q  <= cnt_d;
         bit_q  <= bit_d;
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
         sh_a_q <= sh_a_d;
         sh_b_q <= sh_b_d;
         rxa_q  <= rxa_d;
         rxb_q  <= rxb_d;
         ch_q   <= ch_d;
      end
   end

   assign spi_sclk  = sclk_q;
   assign spi_mosi  = mosi_q;
   assign chip_rxda = rxa_q;
   assign chip_rxdb = rxb_q;
   assign ch_idx    = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_dual.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_spi_dual
//  Purpose  : Directed bench for adc_spi_dual with two-channel sweeps, a
//             behavioural dual-ADC MISO model and fs/fd handshake driver.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_dual;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      int          fd_delay;
      logic [15:0] exp_mosi;
      logic [5:0]  exp_ch;
      logic        exp_done;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, fd;
   logic        busy, done, spi_csn, spi_sclk, spi_mosi, fs;
   logic        spi_misoa, spi_misob;
   logic [5:0]  ch_idx;
   logic [15:0] chip_rxda, chip_rxdb;

   logic [15:0] word_a = 16'h0000;
   logic [15:0] word_b = 16'h0000;
   logic [15:0] mosi_cap = 16'h0000;
   int          rise_cnt = 0;
   int          sclk_total = 0;
   int          fs_cnt = 0;
   int          done_cnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   vec_t        vecs[6];

   adc_spi_dual #(.NUM_CH(2), .SCLK_DIV(2), .CS_GAP(4)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ch_idx(ch_idx), .spi_csn(spi_csn), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_misoa(spi_misoa), .spi_misob(spi_misob),
      .fs(fs), .fd(fd), .chip_rxda(chip_rxda), .chip_rxdb(chip_rxdb)
   );

   always #5 clk = ~clk;

   // Slave model: a new frame starts at CSn fall; data advances after each rising SCLK
   always @(negedge spi_csn or posedge spi_sclk) begin
      if (spi_sclk) begin
         mosi_cap   = {mosi_cap[14:0], spi_mosi};
         rise_cnt   = rise_cnt + 1;
         sclk_total = sclk_total + 1;
      end else begin
         rise_cnt = 0;
      end
   end
   assign spi_misoa = (rise_cnt < 16) ? word_a[4'(15 - rise_cnt)] : 1'b0;
   assign spi_misob = (rise_cnt < 16) ? word_b[4'(15 - rise_cnt)] : 1'b0;

   always @(posedge fs) fs_cnt = fs_cnt + 1;
   always @(negedge clk) if (done) done_cnt = done_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input int d,
                               input logic [15:0] m, input logic [5:0] c, input logic dn);
      vec_t v;
      v.a = a; v.b = b; v.fd_delay = d; v.exp_mosi = m; v.exp_ch = c; v.exp_done = dn;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_fs(input int bound);
      int n = 0;
      while (fs !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("fs_rise", fs, 1);
   endtask

   task automatic wait_csn(input logic lvl, input int bound);
      int n = 0;
      while (spi_csn !== lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("csn_wait", spi_csn, lvl);
   endtask

   // One word: optional start, wait for fs, check captured data, handshake, check sweep end
   task automatic apply_vec(input vec_t v, input bit do_start);
      word_a = v.a;
      word_b = v.b;
      if (do_start) begin
         check("idle_busy", busy, 0);
         pulse_start();
         check("busy_after_start", busy, 1);
      end
      wait_fs(2000);
      check("rxda", chip_rxda, v.a);
      check("rxdb", chip_rxdb, v.b);
      check("ch_idx", ch_idx, v.exp_ch);
      check("mosi_word", mosi_cap, v.exp_mosi);
      check("sclk_rises", rise_cnt, 16);
      check("csn_in_hand", spi_csn, 1);
      repeat (v.fd_delay) @(negedge clk);
      check("fs_held", fs, 1);
      check("rxda_held", chip_rxda, v.a);
      fd = 1'b1;
      @(negedge clk);
      check("fs_drop", fs, 0);
      fd = 1'b0;
      @(negedge clk);
      check("done", done, v.exp_done);
      check("busy_at_next", busy, !v.exp_done);
      if (v.exp_done) begin
         @(negedge clk);
         check("ch_idx_wrap", ch_idx, 0);
         check("busy_idle", busy, 0);
      end
   endtask

   initial begin
      logic bad;
      int   snap, fs0, d0;

      vecs[0] = mk(16'hA5C3, 16'h3C5A, 3, 16'h0000, 6'd0, 1'b0);
      vecs[1] = mk(16'hA5C3, 16'h3C5A, 3, 16'h0100, 6'd1, 1'b1);
      vecs[2] = mk(16'hFFFF, 16'h0000, 1, 16'h0000, 6'd0, 1'b0);
      vecs[3] = mk(16'h0001, 16'h8000, 7, 16'h0100, 6'd1, 1'b1);
      vecs[4] = mk(16'h1234, 16'hFEDC, 0, 16'h0000, 6'd0, 1'b0);
      vecs[5] = mk(16'h8001, 16'h7FFE, 2, 16'h0100, 6'd1, 1'b1);

      rst = 1'b1; start = 1'b0; fd = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_csn", spi_csn, 1);
      check("rst_sclk", spi_sclk, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_csn", spi_csn, 1);
      check("idle_sclk", spi_sclk, 0);
      check("idle_mosi", spi_mosi, 0);
      check("idle_fs", fs, 0);
      check("idle_busy0", busy, 0);
      check("idle_done", done, 0);
      check("idle_ch", ch_idx, 0);
      check("idle_rxda", chip_rxda, 0);
      check("idle_rxdb", chip_rxdb, 0);

      for (int i = 0; i < 6; i++) apply_vec(vecs[i], (i % 2) == 0);

      // Long downstream stall: fs and data frozen, bus quiet, next word waits for fd low
      word_a = 16'hA5C3; word_b = 16'h3C5A;
      pulse_start();
      wait_fs(2000);
      snap = sclk_total;
      bad  = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (fs !== 1'b1 || chip_rxda !== 16'hA5C3 || chip_rxdb !== 16'h3C5A || spi_csn !== 1'b1)
            bad = 1'b1;
      end
      check("stall_stable", bad, 0);
      check("stall_no_sclk", sclk_total, snap);
      fd = 1'b1;
      @(negedge clk);
      check("stall_fs_drop", fs, 0);
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (fs !== 1'b0 || spi_csn !== 1'b1) bad = 1'b1;
      end
      check("rels_holds", bad, 0);
      fd = 1'b0;
      @(negedge clk);
      check("next_csn_high", spi_csn, 1);
      @(negedge clk);
      check("next_csn_low", spi_csn, 0);
      apply_vec(vecs[1], 1'b0);

      // fd already high when GAP ends: no handoff until fd released
      word_a = 16'h5A5A; word_b = 16'hC3C3;
      pulse_start();
      wait_csn(1'b0, 100);
      wait_csn(1'b1, 200);
      fd  = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (fs !== 1'b0) bad = 1'b1;
      end
      check("fd_stuck_no_fs", bad, 0);
      fd = 1'b0;
      @(negedge clk);
      check("fd_release_fs", fs, 1);
      check("fd_stuck_rxda", chip_rxda, 16'h5A5A);
      check("fd_stuck_rxdb", chip_rxdb, 16'hC3C3);
      fd = 1'b1;
      @(negedge clk);
      fd = 1'b0;
      @(negedge clk);
      apply_vec(mk(16'h5A5A, 16'hC3C3, 1, 16'h0100, 6'd1, 1'b1), 1'b0);

      // start pulses during a sweep are ignored
      fs0 = fs_cnt; d0 = done_cnt;
      word_a = 16'h0F0F; word_b = 16'hF0F0;
      pulse_start();
      wait_csn(1'b0, 100);
      repeat (5) @(negedge clk);
      pulse_start();
      apply_vec(mk(16'h0F0F, 16'hF0F0, 2, 16'h0000, 6'd0, 1'b0), 1'b0);
      pulse_start();
      apply_vec(mk(16'h0F0F, 16'hF0F0, 2, 16'h0100, 6'd1, 1'b1), 1'b0);
      repeat (30) @(negedge clk);
      check("busy_start_fs_count", fs_cnt - fs0, 2);
      check("busy_start_done_count", done_cnt - d0, 1);
      check("busy_start_idle", busy, 0);
      check("busy_start_csn", spi_csn, 1);

      // Reset in the middle of SHIFT, then a clean sweep
      fs0 = fs_cnt;
      word_a = 16'h6DB6; word_b = 16'h9249;
      pulse_start();
      begin
         int n = 0;
         while (!(spi_csn === 1'b0 && rise_cnt == 7) && n < 500) begin
            @(negedge clk);
            n++;
         end
      end
      check("mid_rise_cnt", rise_cnt, 7);
      rst = 1'b1;
      #1;
      check("mid_rst_csn", spi_csn, 1);
      check("mid_rst_sclk", spi_sclk, 0);
      check("mid_rst_fs", fs, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_rst_no_fs", fs_cnt - fs0, 0);
      check("mid_rst_rxda", chip_rxda, 0);
      apply_vec(mk(16'h6DB6, 16'h9249, 2, 16'h0000, 6'd0, 1'b0), 1'b1);
      apply_vec(mk(16'h6DB6, 16'h9249, 2, 16'h0100, 6'd1, 1'b1), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adc_spi_dual.md
Name: adc_spi_dual

Overview:
- SPI master for two ADC front-end chips sharing CSn, SCLK and MOSI, each with its own MISO line.
- On a start pulse it sweeps NUM_CH channels. For each channel it issues one 16-bit CONVERT command and captures both 16-bit MISO words in parallel.
- It hands each word pair to the downstream FIFO packer through the fs/fd level handshake.
- Sits between the acquisition controller (start/done) and the FIFO packer (consumes chip_rxda/chip_rxdb).

Parameters:
- NUM_CH, 32, channels per sweep (1..64); ch_idx runs 0..NUM_CH-1.
- SCLK_DIV, 4, clk cycles per SCLK half-period (>=2).
- CS_GAP, 8, minimum clk cycles CSn held high between words (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at sweep end.
- ch_idx  out  6  channel of the word currently in flight or being handed off.
- spi_csn  out  1  chip select, active low.
- spi_sclk  out  1  SPI clock; CPOL=0, CPHA=0.
- spi_mosi  out  1  command bit, MSB first.
- spi_misoa  in  1  chip A data.
- spi_misob  in  1  chip B data.
- fs  out  1  word pair valid; level signal.
- fd  in  1  downstream finished consuming the pair.
- chip_rxda  out  16  chip A word; stable while fs=1.
- chip_rxdb  out  16  chip B word; stable while fs=1.

Behaviour:
- Reset values:
  - busy=0, done=0, fs=0, ch_idx=0.
  - spi_csn=1, spi_sclk=0, spi_mosi=0.
  - chip_rxda=chip_rxdb=0; state=IDLE.
  - Asserting rst mid-word drives spi_csn=1 and spi_sclk=0 immediately; the partial word is discarded and no fs is issued.
- Command word: {2'b00, ch_idx[5:0], 8'h00}.
- State machine: IDLE, SETUP, SHIFT, GAP, HAND, RELS, NEXT.
  - IDLE: start=1 moves to SETUP with ch_idx=0 and busy=1. start in any other state is ignored.
  - SETUP:
    - spi_csn=0 and spi_mosi=command bit 15, with sclk low.
    - Held SCLK_DIV cycles, then enters SHIFT.
  - SHIFT: 16 SCLK periods, each 2*SCLK_DIV clk cycles, low half first.
    - At each rising SCLK, the MISO A/B bits shift into separate 16-bit shift registers, MSB first.
    - At each falling SCLK except the 16th, spi_mosi advances to the next command bit.
    - After the 16th falling edge, spi_csn=1 and the state moves to GAP.
  - GAP:
    - Counts CS_GAP cycles with csn high.
    - On the first GAP cycle, the shift registers load into chip_rxda/chip_rxdb.
    - After the count, moves to HAND.
  - HAND:
    - Entered only when fd=0; otherwise waits in GAP until fd=0.
    - fs=1; data held.
    - When fd=1 is seen, fs=0 on the next cycle and the state moves to RELS.
  - RELS:
    - Waits for fd=0, then moves to NEXT.
    - fs is never re-raised while fd=1.
  - NEXT:
    - If ch_idx==NUM_CH-1: done=1 for one cycle, busy=0, ch_idx=0, then IDLE.
    - Otherwise ch_idx+1 and SETUP.
- Throughput floor per word: SCLK_DIV*33 + CS_GAP + handshake cycles.
  - The downstream packer's handshake latency stretches the sweep; no overrun is possible.
- ch_idx is 6 bits. NUM_CH=64 wraps 63 to 0 only through the done path.
- chip_rxda/chip_rxdb change only on the GAP load cycle; they never change while fs=1.
- fd asserted without fs is ignored, except that it stalls entry into HAND.

Test Plan:
- Reset: hold rst 3 cycles, then idle 20 cycles -> csn=1, sclk=0, fs=0, busy=0, done=0, chip_rxda/b=0.
- Single sweep, NUM_CH=2, SCLK_DIV=2, CS_GAP=4; MISO models return 16'hA5C3 (A) and 16'h3C5A (B) -> MOSI words 16'h0000 then 16'h0100, each frame 16 SCLK rising edges; fs rises with rxda=A5C3, rxdb=3C5A; done pulses once after the 2nd handoff; busy falls on the same cycle.
- Handshake stall: downstream holds fd low for 50 cycles after fs -> fs stays 1, rxda/rxdb unchanged; csn stays high with no new SCLK; fd=1 gives fs=0 next cycle; next word starts only after fd=0.
- fd stuck high before handoff: force fd=1 at GAP end -> fs stays 0 until fd=0, then fs=1.
- start while busy: pulse start mid-sweep -> ignored; exactly NUM_CH fs assertions, one done.
- Reset mid-SHIFT after 7 SCLK edges -> same cycle csn=1, sclk=0, fs=0; a fresh start afterwards produces a full correct sweep from ch_idx=0.
